// File: rtl/fmap_port_scheduler_pkg.sv
// Shared types and default widths for the feature-map port scheduler.
package fmap_port_scheduler_pkg;

    localparam int unsigned DEFAULT_STALL_CNT_BITS = 16;
    localparam int unsigned DEFAULT_DATA_WIDTH     = 48;
    localparam int unsigned DEFAULT_ADDR_WIDTH     = 10;

    typedef enum logic {
        OWNER_CONV = 1'b0,
        OWNER_POOL = 1'b1
    } fmap_owner_t;

    typedef enum logic [1:0] {
        CONV_OWN      = 2'd0,
        DRAIN_TO_POOL = 2'd1,
        POOL_OWN      = 2'd2,
        DRAIN_TO_CONV = 2'd3
    } sched_state_t;

endpackage

// File: rtl/fmap_port_scheduler_if.sv
// Requester-side read/write bundle for one feature-map client (conv or pool).
interface fmap_port_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 48,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_gnt;

    // Requester side drives requests and consumes grants/data.
    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_valid, rd_data, wr_gnt
    );

    // Scheduler side consumes requests and drives grants/data.
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_valid, rd_data, wr_gnt
    );
endinterface

// File: rtl/fmap_port_scheduler_write_stage.sv
// Write-stage register feeding BRAM port B, plus same-address read forwarding.
module fmap_write_stage #(
    parameter int unsigned DATA_WIDTH = 48,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  stage_valid,
    output logic [ADDR_WIDTH-1:0] stage_addr,
    output logic [DATA_WIDTH-1:0] stage_data,
    output logic                  fwd_valid,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    logic fwd_hit_c;

    // A read issued while the staged write to the same word commits would see stale BRAM data.
    always_comb begin
        fwd_hit_c = rd_en && stage_valid && (stage_addr == rd_addr);
    end

    // Stage accepted writes for one cycle and remember forwarded data for the read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_data  <= '0;
            fwd_valid   <= 1'b0;
            fwd_data    <= '0;
        end else if (clear) begin
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_data  <= '0;
            fwd_valid   <= 1'b0;
            fwd_data    <= '0;
        end else begin
            stage_valid <= wr_en;
            if (wr_en) begin
                stage_addr <= wr_addr;
                stage_data <= wr_data;
            end
            fwd_valid <= fwd_hit_c;
            if (fwd_hit_c) begin
                fwd_data <= stage_data;
            end
        end
    end

endmodule

// File: rtl/fmap_port_scheduler.sv
// Time-shares the dual-port feature-map BRAM between the conv and pool engines.
module fmap_port_scheduler
    import fmap_port_scheduler_pkg::*;
#(
    parameter int unsigned BRAM_DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned BRAM_ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned STALL_CNT_BITS  = DEFAULT_STALL_CNT_BITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sys_reset,
    input  logic                       mode_conv,
    output logic                       owner_conv,
    output logic                       switch_done,
    output logic [STALL_CNT_BITS-1:0]  stall_count,
    fmap_port_scheduler_if.slave       conv,
    fmap_port_scheduler_if.slave       pool,
    output logic                       bram_a_en,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_a_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_a_rdata,
    output logic                       bram_b_we,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_b_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram_b_wdata
);

    sched_state_t                state;
    sched_state_t                state_next;
    logic                        owner_conv_next;
    logic                        switch_done_next;
    logic                        conv_own_c;
    logic                        pool_own_c;
    logic                        conv_rd_gnt_c;
    logic                        pool_rd_gnt_c;
    logic                        conv_wr_gnt_c;
    logic                        pool_wr_gnt_c;
    logic                        rd_en_c;
    logic [BRAM_ADDR_WIDTH-1:0]  rd_addr_c;
    logic                        wr_en_c;
    logic [BRAM_ADDR_WIDTH-1:0]  wr_addr_c;
    logic [BRAM_DATA_WIDTH-1:0]  wr_data_c;
    logic                        denied_c;
    logic                        drain_empty_c;
    logic                        rd_inflight;
    fmap_owner_t                 rd_tag;
    logic                        fwd_valid;
    logic [BRAM_DATA_WIDTH-1:0]  fwd_data;
    logic [BRAM_DATA_WIDTH-1:0]  rd_word_c;

    // State register with registered owner flag and switch pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CONV_OWN;
            owner_conv  <= 1'b1;
            switch_done <= 1'b0;
        end else if (sys_reset) begin
            state       <= CONV_OWN;
            owner_conv  <= 1'b1;
            switch_done <= 1'b0;
        end else begin
            state       <= state_next;
            owner_conv  <= owner_conv_next;
            switch_done <= switch_done_next;
        end
    end

    // Next-state: request a drain on mode change, hand over once both pipes are empty.
    always_comb begin
        state_next = state;
        unique case (state)
            CONV_OWN:      if (!mode_conv)   state_next = DRAIN_TO_POOL;
            DRAIN_TO_POOL: if (drain_empty_c) state_next = POOL_OWN;
            POOL_OWN:      if (mode_conv)    state_next = DRAIN_TO_CONV;
            DRAIN_TO_CONV: if (drain_empty_c) state_next = CONV_OWN;
            default:                         state_next = CONV_OWN;
        endcase
    end

    // Outputs: grants only in the owner's own state, owner flag and switch pulse follow the state.
    always_comb begin
        conv_own_c       = 1'b0;
        pool_own_c       = 1'b0;
        owner_conv_next  = 1'b1;
        switch_done_next = 1'b0;
        conv_own_c       = (state == CONV_OWN);
        pool_own_c       = (state == POOL_OWN);
        owner_conv_next  = (state_next == CONV_OWN) || (state_next == DRAIN_TO_POOL);
        switch_done_next = ((state == DRAIN_TO_POOL) || (state == DRAIN_TO_CONV))
                           && (state_next != state);
    end

    always_comb begin
        conv_rd_gnt_c = conv.rd_req && conv_own_c;
        pool_rd_gnt_c = pool.rd_req && pool_own_c;
        conv_wr_gnt_c = conv.wr_req && conv_own_c;
        pool_wr_gnt_c = pool.wr_req && pool_own_c;
        rd_en_c       = conv_rd_gnt_c || pool_rd_gnt_c;
        rd_addr_c     = pool_own_c ? pool.rd_addr : conv.rd_addr;
        wr_en_c       = conv_wr_gnt_c || pool_wr_gnt_c;
        wr_addr_c     = pool_own_c ? pool.wr_addr : conv.wr_addr;
        wr_data_c     = pool_own_c ? pool.wr_data : conv.wr_data;
        denied_c      = (conv.rd_req && !conv_rd_gnt_c) || (pool.rd_req && !pool_rd_gnt_c)
                     || (conv.wr_req && !conv_wr_gnt_c) || (pool.wr_req && !pool_wr_gnt_c);
        drain_empty_c = !rd_inflight && !bram_b_we;
    end

    assign conv.rd_gnt = conv_rd_gnt_c;
    assign pool.rd_gnt = pool_rd_gnt_c;
    assign conv.wr_gnt = conv_wr_gnt_c;
    assign pool.wr_gnt = pool_wr_gnt_c;
    assign bram_a_en   = rd_en_c;
    assign bram_a_addr = rd_addr_c;

    // Track the single outstanding read and which requester it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight <= 1'b0;
            rd_tag      <= OWNER_CONV;
        end else if (sys_reset) begin
            rd_inflight <= 1'b0;
            rd_tag      <= OWNER_CONV;
        end else begin
            rd_inflight <= rd_en_c;
            rd_tag      <= pool_rd_gnt_c ? OWNER_POOL : OWNER_CONV;
        end
    end

    // Saturating count of cycles in which any request was refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (sys_reset) begin
            stall_count <= '0;
        end else if (denied_c && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_BITS'(1);
        end
    end

    // Return data: forwarded write data wins over the stale BRAM word.
    always_comb begin
        rd_word_c = fwd_valid ? fwd_data : bram_a_rdata;
    end

    assign conv.rd_valid = rd_inflight && (rd_tag == OWNER_CONV);
    assign pool.rd_valid = rd_inflight && (rd_tag == OWNER_POOL);
    assign conv.rd_data  = conv.rd_valid ? rd_word_c : '0;
    assign pool.rd_data  = pool.rd_valid ? rd_word_c : '0;

    fmap_write_stage #(
        .DATA_WIDTH (BRAM_DATA_WIDTH),
        .ADDR_WIDTH (BRAM_ADDR_WIDTH)
    ) u_write_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (sys_reset),
        .wr_en       (wr_en_c),
        .wr_addr     (wr_addr_c),
        .wr_data     (wr_data_c),
        .rd_en       (rd_en_c),
        .rd_addr     (rd_addr_c),
        .stage_valid (bram_b_we),
        .stage_addr  (bram_b_addr),
        .stage_data  (bram_b_wdata),
        .fwd_valid   (fwd_valid),
        .fwd_data    (fwd_data)
    );

endmodule

// File: tb/tb_fmap_port_scheduler.sv
// Directed bench for fmap_port_scheduler with a read-first dual-port BRAM model.
module tb_fmap_port_scheduler;

    logic        clk;
    logic        rst_n;
    logic        sys_reset;
    logic        mode_conv;
    logic        owner_conv;
    logic        switch_done;
    logic [15:0] stall_count;
    logic        bram_a_en;
    logic [9:0]  bram_a_addr;
    logic [47:0] bram_a_rdata;
    logic        bram_b_we;
    logic [9:0]  bram_b_addr;
    logic [47:0] bram_b_wdata;
    logic [47:0] mem [0:1023];

    logic        sat_owner_conv;
    logic        sat_switch_done;
    logic [7:0]  sat_stall_count;
    logic        sat_a_en;
    logic [9:0]  sat_a_addr;
    logic [47:0] sat_a_rdata;
    logic        sat_b_we;
    logic [9:0]  sat_b_addr;
    logic [47:0] sat_b_wdata;

    int tests = 0;
    int fails = 0;

    fmap_port_scheduler_if #(.DATA_WIDTH(48), .ADDR_WIDTH(10)) conv_if ();
    fmap_port_scheduler_if #(.DATA_WIDTH(48), .ADDR_WIDTH(10)) pool_if ();
    fmap_port_scheduler_if #(.DATA_WIDTH(48), .ADDR_WIDTH(10)) sat_conv_if ();
    fmap_port_scheduler_if #(.DATA_WIDTH(48), .ADDR_WIDTH(10)) sat_pool_if ();

    fmap_port_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sys_reset    (sys_reset),
        .mode_conv    (mode_conv),
        .owner_conv   (owner_conv),
        .switch_done  (switch_done),
        .stall_count  (stall_count),
        .conv         (conv_if),
        .pool         (pool_if),
        .bram_a_en    (bram_a_en),
        .bram_a_addr  (bram_a_addr),
        .bram_a_rdata (bram_a_rdata),
        .bram_b_we    (bram_b_we),
        .bram_b_addr  (bram_b_addr),
        .bram_b_wdata (bram_b_wdata)
    );

    fmap_port_scheduler #(.STALL_CNT_BITS(8)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .sys_reset    (1'b0),
        .mode_conv    (1'b1),
        .owner_conv   (sat_owner_conv),
        .switch_done  (sat_switch_done),
        .stall_count  (sat_stall_count),
        .conv         (sat_conv_if),
        .pool         (sat_pool_if),
        .bram_a_en    (sat_a_en),
        .bram_a_addr  (sat_a_addr),
        .bram_a_rdata (sat_a_rdata),
        .bram_b_we    (sat_b_we),
        .bram_b_addr  (sat_b_addr),
        .bram_b_wdata (sat_b_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first BRAM: port A returns the pre-write word one cycle after enable.
    always @(posedge clk) begin
        if (bram_a_en) bram_a_rdata <= mem[bram_a_addr];
        if (bram_b_we) mem[bram_b_addr] <= bram_b_wdata;
    end

    assign sat_a_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[5] = 48'h123;
        mem[7] = 48'h55;
        bram_a_rdata = '0;
        rst_n = 1'b0; sys_reset = 1'b0; mode_conv = 1'b1;
        conv_if.rd_req = 0; conv_if.rd_addr = '0; conv_if.wr_req = 0; conv_if.wr_addr = '0; conv_if.wr_data = '0;
        pool_if.rd_req = 0; pool_if.rd_addr = '0; pool_if.wr_req = 0; pool_if.wr_addr = '0; pool_if.wr_data = '0;
        sat_conv_if.rd_req = 0; sat_conv_if.rd_addr = '0; sat_conv_if.wr_req = 0; sat_conv_if.wr_addr = '0; sat_conv_if.wr_data = '0;
        sat_pool_if.rd_req = 0; sat_pool_if.rd_addr = '0; sat_pool_if.wr_req = 0; sat_pool_if.wr_addr = '0; sat_pool_if.wr_data = '0;

        // Reset values
        cyc(); cyc(); #1;
        chk("rst_owner", 64'(owner_conv), 64'd1);
        chk("rst_switch", 64'(switch_done), 64'd0);
        chk("rst_stall", 64'(stall_count), 64'd0);
        chk("rst_bwe", 64'(bram_b_we), 64'd0);
        chk("rst_rvalid", 64'(conv_if.rd_valid), 64'd0);
        cyc(); rst_n = 1'b1;

        // Conv read of addr 5, 1-cycle latency
        cyc(); conv_if.rd_req = 1; conv_if.rd_addr = 10'd5; #1;
        chk("rd_gnt", 64'(conv_if.rd_gnt), 64'd1);
        chk("rd_a_en", 64'(bram_a_en), 64'd1);
        chk("rd_a_addr", 64'(bram_a_addr), 64'd5);
        chk("rd_pool_gnt", 64'(pool_if.rd_gnt), 64'd0);
        cyc(); conv_if.rd_req = 0; #1;
        chk("rd_valid", 64'(conv_if.rd_valid), 64'd1);
        chk("rd_data", 64'(conv_if.rd_data), 64'h123);
        chk("rd_pool_valid", 64'(pool_if.rd_valid), 64'd0);
        chk("rd_pool_data", 64'(pool_if.rd_data), 64'd0);
        chk("rd_stall0", 64'(stall_count), 64'd0);

        // Denied pool read bumps the stall counter
        cyc(); pool_if.rd_req = 1; pool_if.rd_addr = 10'd5; #1;
        chk("deny_pool_gnt", 64'(pool_if.rd_gnt), 64'd0);
        cyc(); pool_if.rd_req = 0; #1;
        chk("deny_stall1", 64'(stall_count), 64'd1);

        // Write 0xAA to 7, then read 7: forwarded over stale 0x55
        cyc(); conv_if.wr_req = 1; conv_if.wr_addr = 10'd7; conv_if.wr_data = 48'hAA; #1;
        chk("fw_wr_gnt", 64'(conv_if.wr_gnt), 64'd1);
        cyc(); conv_if.wr_req = 0; conv_if.rd_req = 1; conv_if.rd_addr = 10'd7; #1;
        chk("fw_bwe", 64'(bram_b_we), 64'd1);
        chk("fw_baddr", 64'(bram_b_addr), 64'd7);
        chk("fw_bdata", 64'(bram_b_wdata), 64'hAA);
        chk("fw_rd_gnt", 64'(conv_if.rd_gnt), 64'd1);
        cyc(); conv_if.rd_req = 0; #1;
        chk("fw_rd_data", 64'(conv_if.rd_data), 64'hAA);
        chk("fw_bwe_off", 64'(bram_b_we), 64'd0);

        // Same-cycle read and write to 7 returns the old word
        cyc(); conv_if.wr_req = 1; conv_if.wr_data = 48'hBB; conv_if.rd_req = 1; #1;
        cyc(); conv_if.wr_req = 0; conv_if.rd_req = 0; #1;
        chk("same_old", 64'(conv_if.rd_data), 64'hAA);
        cyc(); conv_if.rd_req = 1; #1;
        cyc(); conv_if.rd_req = 0; #1;
        chk("same_new", 64'(conv_if.rd_data), 64'hBB);

        // Switch to pool with a conv read in flight
        cyc(); conv_if.rd_req = 1; conv_if.rd_addr = 10'd5; mode_conv = 0; #1;
        chk("dr_rd_gnt", 64'(conv_if.rd_gnt), 64'd1);
        cyc(); conv_if.rd_req = 0; pool_if.rd_req = 1; pool_if.rd_addr = 10'd7; #1;
        chk("dr_valid", 64'(conv_if.rd_valid), 64'd1);
        chk("dr_data", 64'(conv_if.rd_data), 64'h123);
        chk("dr_pgnt1", 64'(pool_if.rd_gnt), 64'd0);
        chk("dr_owner1", 64'(owner_conv), 64'd1);
        chk("dr_sw1", 64'(switch_done), 64'd0);
        cyc(); #1;
        chk("dr_pgnt2", 64'(pool_if.rd_gnt), 64'd0);
        chk("dr_sw2", 64'(switch_done), 64'd0);
        cyc(); #1;
        chk("dr_sw3", 64'(switch_done), 64'd1);
        chk("dr_owner3", 64'(owner_conv), 64'd0);
        chk("dr_pgnt3", 64'(pool_if.rd_gnt), 64'd1);
        chk("dr_stall3", 64'(stall_count), 64'd3);
        cyc(); pool_if.rd_req = 0; #1;
        chk("dr_sw4", 64'(switch_done), 64'd0);
        chk("dr_pvalid", 64'(pool_if.rd_valid), 64'd1);
        chk("dr_pdata", 64'(pool_if.rd_data), 64'hBB);

        // Pool write to 9, then hand back to conv
        cyc(); pool_if.wr_req = 1; pool_if.wr_addr = 10'd9; pool_if.wr_data = 48'h77; mode_conv = 1; #1;
        chk("bk_wgnt", 64'(pool_if.wr_gnt), 64'd1);
        cyc(); pool_if.wr_req = 0; #1;
        chk("bk_bwe", 64'(bram_b_we), 64'd1);
        chk("bk_baddr", 64'(bram_b_addr), 64'd9);
        chk("bk_owner1", 64'(owner_conv), 64'd0);
        cyc(); #1;
        chk("bk_sw2", 64'(switch_done), 64'd0);
        cyc(); #1;
        chk("bk_sw3", 64'(switch_done), 64'd1);
        chk("bk_owner3", 64'(owner_conv), 64'd1);

        // Mode reverts during DRAIN_TO_POOL: full round trip, two pulses
        cyc(); mode_conv = 0; #1;
        cyc(); mode_conv = 1; conv_if.rd_req = 1; conv_if.rd_addr = 10'd5; #1;
        chk("rv_gnt1", 64'(conv_if.rd_gnt), 64'd0);
        chk("rv_sw1", 64'(switch_done), 64'd0);
        chk("rv_owner1", 64'(owner_conv), 64'd1);
        cyc(); #1;
        chk("rv_sw2", 64'(switch_done), 64'd1);
        chk("rv_owner2", 64'(owner_conv), 64'd0);
        chk("rv_gnt2", 64'(conv_if.rd_gnt), 64'd0);
        cyc(); #1;
        chk("rv_sw3", 64'(switch_done), 64'd0);
        chk("rv_owner3", 64'(owner_conv), 64'd0);
        chk("rv_gnt3", 64'(conv_if.rd_gnt), 64'd0);
        cyc(); #1;
        chk("rv_sw4", 64'(switch_done), 64'd1);
        chk("rv_owner4", 64'(owner_conv), 64'd1);
        chk("rv_gnt4", 64'(conv_if.rd_gnt), 64'd1);
        cyc(); conv_if.rd_req = 0; #1;
        chk("rv_data", 64'(conv_if.rd_data), 64'h123);

        // Async reset with a staged write: write dropped, outputs back to reset
        cyc(); conv_if.wr_req = 1; conv_if.wr_addr = 10'd9; conv_if.wr_data = 48'hDEAD; #1;
        cyc(); conv_if.wr_req = 0; #1;
        chk("ar_bwe_pre", 64'(bram_b_we), 64'd1);
        rst_n = 1'b0; #1;
        chk("ar_bwe", 64'(bram_b_we), 64'd0);
        chk("ar_stall", 64'(stall_count), 64'd0);
        chk("ar_owner", 64'(owner_conv), 64'd1);
        chk("ar_sw", 64'(switch_done), 64'd0);
        cyc(); rst_n = 1'b1;
        cyc(); conv_if.rd_req = 1; conv_if.rd_addr = 10'd9; #1;
        cyc(); conv_if.rd_req = 0; #1;
        chk("ar_kept", 64'(conv_if.rd_data), 64'h77);

        // Synchronous clear
        cyc(); pool_if.rd_req = 1; #1;
        cyc(); pool_if.rd_req = 0; #1;
        chk("sr_stall1", 64'(stall_count), 64'd1);
        sys_reset = 1'b1;
        cyc(); sys_reset = 1'b0; #1;
        chk("sr_stall0", 64'(stall_count), 64'd0);
        chk("sr_owner", 64'(owner_conv), 64'd1);

        // 300 denied cycles: 16-bit counts, 8-bit saturates
        cyc(); pool_if.wr_req = 1; sat_pool_if.wr_req = 1;
        repeat (300) cyc();
        pool_if.wr_req = 0; sat_pool_if.wr_req = 0; #1;
        chk("st_300", 64'(stall_count), 64'd300);
        chk("st_sat", 64'(sat_stall_count), 64'd255);
        cyc(); #1;
        chk("st_hold", 64'(stall_count), 64'd300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fmap_port_scheduler.md
Name: fmap_port_scheduler

Overview:
- Owns the dual-port feature-map BRAM and time-shares it between the convolution engine and the sum-pooling engine.
- Port A is dedicated to reads and port B to writes.
- A mode request from the top-level processor FSM selects the owner. Ownership changes only after the current owner's in-flight read and pending write have both retired.
- Forwards write data on a same-address read-after-write so that read-modify-write sequences never see stale data.

Parameters:
- BRAM_DATA_WIDTH, 48, feature-map word width (CHANNELS*BITS_PER_CHANNEL).
- BRAM_ADDR_WIDTH, 10, feature-map address width.
- STALL_CNT_BITS, 16, width of the saturating denied-request counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sys_reset  in  1  synchronous clear; same effect as reset
- mode_conv  in  1  requested owner: 1=conv, 0=pool
- owner_conv  out  1  current owner: 1=conv, 0=pool
- switch_done  out  1  one-cycle pulse when ownership changes
- stall_count  out  STALL_CNT_BITS  saturating count of denied requests
- conv_rd_req / pool_rd_req  in  1  read request
- conv_rd_addr / pool_rd_addr  in  BRAM_ADDR_WIDTH  read address
- conv_rd_gnt / pool_rd_gnt  out  1  read accepted this cycle
- conv_rd_valid / pool_rd_valid  out  1  read data valid
- conv_rd_data / pool_rd_data  out  BRAM_DATA_WIDTH  read data
- conv_wr_req / pool_wr_req  in  1  write request
- conv_wr_addr / pool_wr_addr  in  BRAM_ADDR_WIDTH  write address
- conv_wr_data / pool_wr_data  in  BRAM_DATA_WIDTH  write data
- conv_wr_gnt / pool_wr_gnt  out  1  write accepted this cycle
- bram_a_en  out  1  port A read enable
- bram_a_addr  out  BRAM_ADDR_WIDTH  port A address
- bram_a_rdata  in  BRAM_DATA_WIDTH  port A data, one cycle after bram_a_en
- bram_b_we  out  1  port B write enable
- bram_b_addr  out  BRAM_ADDR_WIDTH  port B address
- bram_b_wdata  out  BRAM_DATA_WIDTH  port B data

Behaviour:
- **Reset values** (asynchronous rst_n or synchronous sys_reset):
  - State is CONV_OWN and owner_conv=1.
  - All gnt, valid, bram_a_en, bram_b_we and switch_done outputs are 0.
  - stall_count=0, and the read-in-flight and write-stage registers are cleared.
  - An in-flight transaction is dropped: no rd_valid is issued for it and the staged write is not committed.
- **States:** CONV_OWN, DRAIN_TO_POOL, POOL_OWN, DRAIN_TO_CONV.
  - CONV_OWN -> DRAIN_TO_POOL when mode_conv=0.
  - POOL_OWN -> DRAIN_TO_CONV when mode_conv=1.
  - DRAIN_* -> opposite *_OWN once the read-in-flight flag and the write-stage valid are both 0. switch_done pulses on that transition cycle; owner_conv updates in the same cycle as the state register.
  - If mode_conv reverts during a DRAIN_* state, the drain still completes and the opposite owner is entered. It then drains back on the next cycle; no short-circuit.
- **Grants:**
  - Combinational: rd_gnt = rd_req, and wr_gnt = wr_req, only for the owner and only in its *_OWN state.
  - In DRAIN_* states and for the non-owner, gnt=0.
  - Every cycle with any denied req (either requester, read or write) increments stall_count by 1; the counter saturates at all-ones.
- **Read path:**
  - A granted read drives bram_a_en=1 and bram_a_addr in the same cycle.
  - The read-in-flight flag and the owner tag are registered.
  - The next cycle, the tagged requester sees rd_valid=1; latency is 1 cycle.
  - rd_data of the non-tagged requester is 0.
- **Write path:**
  - A granted write is captured into the write-stage register (valid, addr, data).
  - The next cycle drives bram_b_we, bram_b_addr and bram_b_wdata; write latency is 1 cycle.
  - Back-to-back writes are accepted every cycle.
- **Forwarding:**
  - A read is granted in cycle t; a write to the same address was granted in cycle t-1, so its write stage commits in cycle t.
  - A registered forward flag then makes rd_data in cycle t+1 equal the forwarded write data instead of bram_a_rdata.
  - A read and a write to the same address granted in the same cycle return the old BRAM data; write-then-read ordering is the requester's responsibility.
- No simultaneous-owner case exists: exactly one requester may be granted per cycle per port.

Decomposition:
- snn_interfaces_pkg gains:
  - the typedef fmap_owner_t {OWNER_CONV, OWNER_POOL};
  - the typedef sched_state_t for the four states;
  - the constant DEFAULT_STALL_CNT_BITS=16.
- One sub-module, fmap_write_stage, holds the write-stage register and the address-compare forward logic. The FSM, grants and read path stay at the top level.

Test Plan:
- After reset: owner_conv=1, conv_rd_req=1 at addr 5 with BRAM[5]=0x123 -> conv_rd_gnt=1 the same cycle, then conv_rd_valid=1 with conv_rd_data=0x123 the next cycle. pool_rd_gnt=0 throughout and stall_count increments only if pool requests.
- conv_wr addr 7 data 0xAA in cycle t, conv_rd addr 7 in cycle t+1 -> bram_b_we=1 at t+1, and conv_rd_data=0xAA at t+2 via forwarding rather than the old BRAM value.
- A conv read is in flight when mode_conv drops to 0 -> state enters DRAIN_TO_POOL and the conv read completes. switch_done pulses exactly one cycle after the drain is empty, owner_conv=0, and pool_rd_gnt goes high the next cycle.
- pool_wr_req held for 300 cycles while conv owns -> stall_count reaches 300. With STALL_CNT_BITS=8 it saturates at 255.
- rst_n asserted mid-write (write stage valid) -> bram_b_we=0 immediately, the write is not committed, and all outputs return to their reset values.
- mode_conv toggled 0->1 during DRAIN_TO_POOL -> POOL_OWN is entered for one cycle, then DRAIN_TO_CONV, then CONV_OWN, with two switch_done pulses.
